// File: rtl/flag_register_if.sv
// rtl/flag_register_if.sv - Flag-register control and status bundle.
interface flag_register_if;
    logic stall;
    logic cf_in;
    logic nf_in;
    logic zf_in;
    logic cf_we;
    logic nf_we;
    logic zf_we;
    logic setc;
    logic clrc;
    logic jc;
    logic jn;
    logic jz;
    logic int_save;
    logic rti_restore;
    logic cf;
    logic nf;
    logic zf;
    logic shadow_full;
    logic shadow_empty;
    logic stack_err;

    modport master (
        output stall, cf_in, nf_in, zf_in, cf_we, nf_we, zf_we,
               setc, clrc, jc, jn, jz, int_save, rti_restore,
        input  cf, nf, zf, shadow_full, shadow_empty, stack_err
    );

    modport slave (
        input  stall, cf_in, nf_in, zf_in, cf_we, nf_we, zf_we,
               setc, clrc, jc, jn, jz, int_save, rti_restore,
        output cf, nf, zf, shadow_full, shadow_empty, stack_err
    );
endinterface

// File: rtl/flag_register.sv
// rtl/flag_register.sv - Carry/negative/zero condition-code register with interrupt shadow stack.
// Optional FLAG_BYPASS_EN: flag outputs show the same-cycle next value (excluding jump consume).
module flag_register #(
    parameter int SHADOW_DEPTH = 2,
    parameter int PTR_W        = 2
) (
    input  logic           clk,
    input  logic           rst,
    flag_register_if.slave bus
);

    logic             cf_q, nf_q, zf_q;
    logic             cf_d, nf_d, zf_d;
    logic             cf_w, nf_w, zf_w;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [2:0]       slot_q [SHADOW_DEPTH];
    logic [2:0]       slot_d [SHADOW_DEPTH];
    logic             stack_err_q, stack_err_d;
    logic             full, empty, do_push, do_pop;
    logic [2:0]       top;

    always_comb begin
        full    = (ptr_q == PTR_W'(SHADOW_DEPTH));
        empty   = (ptr_q == '0);
        do_push = bus.int_save & ~full;
        do_pop  = bus.rti_restore & ~bus.int_save & ~empty;

        top = '0;
        for (int i = 0; i < SHADOW_DEPTH; i++) begin
            if (ptr_q == PTR_W'(i + 1)) begin
                top = slot_q[i];
            end
        end

        // cf_w/nf_w/zf_w are the next flags before any taken-jump consume;
        // they also feed the bypass path, which must not depend on jump decode.
        if (do_pop) begin
            {cf_w, nf_w, zf_w} = top;
        end else begin
            cf_w = bus.cf_we ? bus.cf_in : (bus.setc ? 1'b1 : (bus.clrc ? 1'b0 : cf_q));
            nf_w = bus.nf_we ? bus.nf_in : nf_q;
            zf_w = bus.zf_we ? bus.zf_in : zf_q;
        end

        cf_d = cf_w;
        nf_d = nf_w;
        zf_d = zf_w;
        if (!do_pop) begin
            if (!bus.cf_we && !bus.setc && !bus.clrc && bus.jc && cf_q) cf_d = 1'b0;
            if (!bus.nf_we && bus.jn && nf_q) nf_d = 1'b0;
            if (!bus.zf_we && bus.jz && zf_q) zf_d = 1'b0;
        end

        for (int i = 0; i < SHADOW_DEPTH; i++) begin
            slot_d[i] = slot_q[i];
            if (do_push && ptr_q == PTR_W'(i)) begin
                slot_d[i] = {cf_q, nf_q, zf_q};
            end
        end

        ptr_d = ptr_q;
        if (do_push) begin
            ptr_d = ptr_q + PTR_W'(1);
        end else if (do_pop) begin
            ptr_d = ptr_q - PTR_W'(1);
        end

        stack_err_d = (bus.int_save & bus.rti_restore)
                    | (bus.int_save & full)
                    | (bus.rti_restore & ~bus.int_save & empty);

        if (bus.stall) begin
            cf_d        = cf_q;
            nf_d        = nf_q;
            zf_d        = zf_q;
            ptr_d       = ptr_q;
            stack_err_d = 1'b0;
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
                slot_d[i] = slot_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cf_q        <= 1'b0;
            nf_q        <= 1'b0;
            zf_q        <= 1'b0;
            ptr_q       <= '0;
            stack_err_q <= 1'b0;
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
                slot_q[i] <= 3'b000;
            end
        end else begin
            cf_q        <= cf_d;
            nf_q        <= nf_d;
            zf_q        <= zf_d;
            ptr_q       <= ptr_d;
            stack_err_q <= stack_err_d;
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

`ifdef FLAG_BYPASS_EN
    assign bus.cf = rst & (bus.stall ? cf_q : cf_w);
    assign bus.nf = rst & (bus.stall ? nf_q : nf_w);
    assign bus.zf = rst & (bus.stall ? zf_q : zf_w);
`else
    assign bus.cf = cf_q;
    assign bus.nf = nf_q;
    assign bus.zf = zf_q;
`endif

    assign bus.shadow_full  = full;
    assign bus.shadow_empty = empty;
    assign bus.stack_err    = stack_err_q;

endmodule

// File: tb/tb_flag_register.sv
// tb/tb_flag_register.sv - Randomized and directed checks of flag_register against a queue-based model.
module tb_flag_register;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    flag_register_if bus ();

    flag_register #(.SHADOW_DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: flags as {cf,nf,zf}, shadow stack as a queue (back = top).
    logic [2:0] m_flags;
    logic [2:0] m_stack [$];
    logic       m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        bus.stall = 0; bus.cf_in = 0; bus.nf_in = 0; bus.zf_in = 0;
        bus.cf_we = 0; bus.nf_we = 0; bus.zf_we = 0; bus.setc = 0; bus.clrc = 0;
        bus.jc = 0; bus.jn = 0; bus.jz = 0; bus.int_save = 0; bus.rti_restore = 0;
    endtask

    task automatic model_reset();
        m_flags = 3'b000;
        m_stack.delete();
        m_err = 1'b0;
    endtask

    task automatic model_update();
        logic [2:0] cur;
        logic [2:0] nxt;
        bit popping;
        cur = m_flags;
        if (bus.stall) begin
            m_err = 1'b0;
            return;
        end
        m_err = 1'b0;
        popping = 0;
        if (bus.int_save) begin
            if (bus.rti_restore) m_err = 1'b1;
            if (m_stack.size() < DEPTH) m_stack.push_back(cur);
            else m_err = 1'b1;
        end else if (bus.rti_restore) begin
            if (m_stack.size() == 0) m_err = 1'b1;
            else popping = 1;
        end
        if (popping) begin
            nxt = m_stack.pop_back();
        end else begin
            if (bus.cf_we)              nxt[2] = bus.cf_in;
            else if (bus.setc)          nxt[2] = 1'b1;
            else if (bus.clrc)          nxt[2] = 1'b0;
            else if (bus.jc && cur[2])  nxt[2] = 1'b0;
            else                        nxt[2] = cur[2];
            if (bus.nf_we)              nxt[1] = bus.nf_in;
            else if (bus.jn && cur[1])  nxt[1] = 1'b0;
            else                        nxt[1] = cur[1];
            if (bus.zf_we)              nxt[0] = bus.zf_in;
            else if (bus.jz && cur[0])  nxt[0] = 1'b0;
            else                        nxt[0] = cur[0];
        end
        m_flags = nxt;
    endtask

    function automatic logic [2:0] exp_flags();
        logic [2:0] v;
        v = m_flags;
`ifdef FLAG_BYPASS_EN
        if (!bus.stall) begin
            if (bus.rti_restore && !bus.int_save && m_stack.size() > 0) begin
                v = m_stack[$];
            end else begin
                v[2] = bus.cf_we ? bus.cf_in : (bus.setc ? 1'b1 : (bus.clrc ? 1'b0 : m_flags[2]));
                v[1] = bus.nf_we ? bus.nf_in : m_flags[1];
                v[0] = bus.zf_we ? bus.zf_in : m_flags[0];
            end
        end
`endif
        return v;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_flags"}, {29'd0, bus.cf, bus.nf, bus.zf}, {29'd0, exp_flags()});
        check({tag, "_full"},  {31'd0, bus.shadow_full},  {31'd0, m_stack.size() == DEPTH});
        check({tag, "_empty"}, {31'd0, bus.shadow_empty}, {31'd0, m_stack.size() == 0});
        check({tag, "_err"},   {31'd0, bus.stack_err},    {31'd0, m_err});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check_all(tag);
    endtask

    // Drop inputs and let outputs settle so constant checks see registered flags.
    task automatic settle();
        idle();
        #1;
    endtask

    task automatic write_flags(input logic [2:0] f);
        idle();
        bus.cf_we = 1; bus.nf_we = 1; bus.zf_we = 1;
        {bus.cf_in, bus.nf_in, bus.zf_in} = f;
        step("wr");
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        check({tag, "_rst_flags"}, {29'd0, bus.cf, bus.nf, bus.zf}, 32'd0);
        check({tag, "_rst_empty"}, {31'd0, bus.shadow_empty}, 32'd1);
        check({tag, "_rst_err"},   {31'd0, bus.stack_err}, 32'd0);
        model_reset();
        #1 rst = 1'b1;
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b1;

        // Asynchronous reset mid-cycle with all flags set and a push pending.
        write_flags(3'b111);
        settle();
        check("pre_rst_111", {29'd0, bus.cf, bus.nf, bus.zf}, 32'd7);
        bus.int_save = 1;
        async_reset("mid");
        idle();
        step("after_rst");

        // ALU write then consume; ALU write beats consume.
        idle(); bus.cf_we = 1; bus.cf_in = 1; step("alu");
        settle(); check("alu_cf1", {31'd0, bus.cf}, 32'd1);
        idle(); bus.jc = 1; step("consume");
        settle(); check("consume_cf0", {31'd0, bus.cf}, 32'd0);
        idle(); bus.cf_we = 1; bus.cf_in = 1; bus.jc = 1; step("alu_vs_jc");
        settle(); check("alu_wins", {31'd0, bus.cf}, 32'd1);

        // SETC/CLRC leave nf/zf alone.
        write_flags(3'b011);
        idle(); bus.setc = 1; bus.clrc = 1; step("setclr");
        settle(); check("setc_wins", {29'd0, bus.cf, bus.nf, bus.zf}, 32'd7);
        idle(); bus.clrc = 1; step("clrc");
        settle(); check("clrc_only", {29'd0, bus.cf, bus.nf, bus.zf}, 32'd3);

        // Nested interrupts restore in reverse order.
        write_flags(3'b101);
        idle(); bus.int_save = 1; step("save1");
        write_flags(3'b010);
        idle(); bus.int_save = 1; step("save2");
        settle(); check("nest_full", {31'd0, bus.shadow_full}, 32'd1);
        write_flags(3'b111);
        idle(); bus.rti_restore = 1; step("rti1");
        settle(); check("rti1_010", {29'd0, bus.cf, bus.nf, bus.zf}, 32'd2);
        idle(); bus.rti_restore = 1; step("rti2");
        settle(); check("rti2_101", {29'd0, bus.cf, bus.nf, bus.zf}, 32'd5);
        check("nest_empty", {31'd0, bus.shadow_empty}, 32'd1);

        // Stack errors: overflow, underflow, save+rti together.
        write_flags(3'b100);
        idle(); bus.int_save = 1; step("fill1");
        write_flags(3'b001);
        idle(); bus.int_save = 1; step("fill2");
        write_flags(3'b110);
        idle(); bus.int_save = 1; step("overflow");
        settle(); check("ovf_err", {31'd0, bus.stack_err}, 32'd1);
        idle(); step("ovf_clear");
        check("ovf_pulse1", {31'd0, bus.stack_err}, 32'd0);
        idle(); bus.rti_restore = 1; step("pop_a");
        settle(); check("ovf_keep_a", {29'd0, bus.cf, bus.nf, bus.zf}, 32'd1);
        idle(); bus.rti_restore = 1; step("pop_b");
        settle(); check("ovf_keep_b", {29'd0, bus.cf, bus.nf, bus.zf}, 32'd4);
        idle(); bus.rti_restore = 1; step("underflow");
        settle(); check("udf_err", {31'd0, bus.stack_err}, 32'd1);
        check("udf_flags", {29'd0, bus.cf, bus.nf, bus.zf}, 32'd4);
        idle(); bus.int_save = 1; bus.rti_restore = 1; step("save_rti");
        settle(); check("sr_err", {31'd0, bus.stack_err}, 32'd1);
        check("sr_pushed", {31'd0, bus.shadow_empty}, 32'd0);

        // Stall holds everything.
        write_flags(3'b000);
        idle(); bus.stall = 1; bus.zf_we = 1; bus.zf_in = 1; bus.int_save = 1; step("stall");
        settle(); check("stall_zf", {31'd0, bus.zf}, 32'd0);
`ifdef FLAG_BYPASS_EN
        idle(); bus.zf_we = 1; bus.zf_in = 1; #1;
        check("bypass_zf", {31'd0, bus.zf}, 32'd1);
        step("bypass_edge");
`endif

        // Randomized traffic with occasional asynchronous reset.
        for (int n = 0; n < 3000; n++) begin
            idle();
            bus.stall       = ($urandom_range(0, 9) == 0);
            {bus.cf_in, bus.nf_in, bus.zf_in} = 3'($urandom);
            bus.cf_we       = ($urandom_range(0, 3) == 0);
            bus.nf_we       = ($urandom_range(0, 3) == 0);
            bus.zf_we       = ($urandom_range(0, 3) == 0);
            bus.setc        = ($urandom_range(0, 5) == 0);
            bus.clrc        = ($urandom_range(0, 5) == 0);
            bus.jc          = ($urandom_range(0, 2) == 0);
            bus.jn          = ($urandom_range(0, 2) == 0);
            bus.jz          = ($urandom_range(0, 2) == 0);
            bus.int_save    = ($urandom_range(0, 4) == 0);
            bus.rti_restore = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rnd");
            end
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
